alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters and returns one response at a time.
// Optional macro ALU_ARBITER_DIV_ZERO_GUARD_EN answers divide-by-zero locally instead of issuing it.
module alu_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_op1,
  input  logic [7:0] req0_op2,
  input  logic [7:0] req0_opcode,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_op1,
  input  logic [7:0] req1_op2,
  input  logic [7:0] req1_opcode,
  output logic       req1_ready,
  output logic [7:0] alu_operator1,
  output logic [7:0] alu_operator2,
  output logic [7:0] alu_operation,
  input  logic [7:0] alu_result,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_overflow,
  output logic       rsp_error,
  input  logic       rsp_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state, state_nxt;
  logic       prio;
  logic [3:0] cnt;

  logic       any_valid;
  logic       grant_id;
  logic [7:0] sel_op1, sel_op2, sel_opc;
  logic       bad_opc;
  logic       div_zero;
  logic       skip_issue;
  logic       accept;
  logic       issue_last;
  logic       rsp_done;

  // Contention goes to the priority bit; a lone requester always wins.
  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? prio : req1_valid;
  assign sel_op1   = grant_id ? req1_op1    : req0_op1;
  assign sel_op2   = grant_id ? req1_op2    : req0_op2;
  assign sel_opc   = grant_id ? req1_opcode : req0_opcode;
  assign bad_opc   = (sel_opc > 8'd5);

`ifdef ALU_ARBITER_DIV_ZERO_GUARD_EN
  assign div_zero = (sel_opc == 8'd5) && (sel_op2 == 8'd0);
`else
  assign div_zero = 1'b0;
`endif

  assign skip_issue = bad_opc | div_zero;
  assign issue_last = (state == ISSUE) && (cnt == 4'd1);
  assign rsp_done   = (state == RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept    = 1'b1;
          state_nxt = skip_issue ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by rst_n so it reads 0 the instant reset asserts.
  assign req0_ready = rst_n & accept & ~grant_id;
  assign req1_ready = rst_n & accept &  grant_id;
  assign rsp_valid  = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (accept && !skip_issue) begin
      cnt <= SETTLE_CNT;
    end else if (state == ISSUE) begin
      cnt <= cnt - 4'd1;
    end else begin
      cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (rsp_done) begin
      prio <= ~rsp_id;
    end
  end

  // ALU port registers only change when an operation is really issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_operator1 <= 8'd0;
      alu_operator2 <= 8'd0;
      alu_operation <= 8'd0;
    end else if (accept && !skip_issue) begin
      alu_operator1 <= sel_op1;
      alu_operator2 <= sel_op2;
      alu_operation <= sel_opc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id       <= 1'b0;
      rsp_result   <= 8'd0;
      rsp_overflow <= 1'b0;
      rsp_error    <= 1'b0;
    end else if (accept) begin
      rsp_id <= grant_id;
      if (bad_opc) begin
        rsp_result   <= 8'h00;
        rsp_overflow <= 1'b0;
        rsp_error    <= 1'b1;
      end else if (div_zero) begin
        rsp_result   <= 8'hFF;
        rsp_overflow <= 1'b1;
        rsp_error    <= 1'b0;
      end else begin
        rsp_error    <= 1'b0;
      end
    end else if (issue_last) begin
      rsp_result   <= alu_result;
      rsp_overflow <= alu_overflow;
    end
  end

endmodule
